// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and constants for the max/min reduction block
//
// Purpose : FSM state encoding and mode constants used by maxmin_reduce and
//           better_cmp.
// Contents: state_e (IDLE, ACCUM, HOLD), MODE_MAX, MODE_MIN.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/maxmin_reduce_better_cmp.sv
// rtl/maxmin_reduce_better_cmp.sv - strict-better comparator for the reduction
//
// Purpose : combinational test of whether a candidate element strictly beats
//           the current best under the selected mode.
// Ports   : cand_i   [N:0]  candidate element
//           best_i   [N:0]  current best element
//           mode_i          MODE_MAX or MODE_MIN
//           better_o        candidate is strictly greater (max) / less (min)
module better_cmp
  import gcd_pkg::*;
#(
  parameter int N      = 4,
  parameter int SIGNED = 0
) (
  input  logic [N:0] cand_i,
  input  logic [N:0] best_i,
  input  logic       mode_i,
  output logic       better_o
);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both interpretations.
  localparam logic [N:0] BIAS = (SIGNED != 0) ? ~({(N+1){1'b1}} >> 1) : '0;

  logic [N:0] cand_k;
  logic [N:0] best_k;

  assign cand_k = cand_i ^ BIAS;
  assign best_k = best_i ^ BIAS;

  // Strict comparison: ties keep the earlier element.
  assign better_o = (mode_i == MODE_MIN) ? (cand_k < best_k) : (cand_k > best_k);

endmodule

// File: rtl/maxmin_reduce.sv
// rtl/maxmin_reduce.sv - streaming frame max/min reduction with index and count
//
// Purpose : consumes a frame of elements (terminated by in_last) and returns
//           the winning element, its zero-based position, the saturating
//           element count and an overflow flag.
// Ports   : clk, rst_n                 clock, async active-low reset
//           in_valid/in_ready          element handshake
//           in_data [N:0], in_last     element and end-of-frame marker
//           mode                       0 = max, 1 = min (taken from first element)
//           out_valid/out_ready        result handshake
//           out_value [N:0]            winning element
//           out_index [IDX_W-1:0]      position of winner (saturating)
//           out_count [IDX_W-1:0]      elements in frame (saturating)
//           out_ovf                    frame exceeded 2^IDX_W-1 elements
module maxmin_reduce
  import gcd_pkg::*;
#(
  parameter int N      = 4,
  parameter int IDX_W  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       out_value,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [IDX_W-1:0] POS_MAX = '1;

  state_e           state_q, state_d;
  logic [N:0]       best_q, best_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;
  logic             better;

  better_cmp #(
    .N      (N),
    .SIGNED (SIGNED)
  ) u_cmp (
    .cand_i   (in_data),
    .best_i   (best_q),
    .mode_i   (mode_q),
    .better_o (better)
  );

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);

  // pos_q counts accepted elements, so before incrementing it is also the
  // zero-based position of the element currently being accepted.
  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          best_d  = in_data;
          idx_d   = '0;
          pos_d   = IDX_W'(1);
          mode_d  = mode;
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (better) begin
            best_d = in_data;
            idx_d  = pos_q;
          end
          if (pos_q == POS_MAX) begin
            ovf_d = 1'b1;
          end else begin
            pos_d = pos_q + IDX_W'(1);
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      best_q  <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= MODE_MAX;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  assign out_value = best_q;
  assign out_index = idx_q;
  assign out_count = pos_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/maxmin_reduce.md
MAXMIN_REDUCE -- requirements
Module: maxmin_reduce

Interface
REQ-001 Parameter N, default 4, data MSB index; data width is N+1 bits.
REQ-002 Parameter IDX_W, default 4, width of element index and count fields.
REQ-003 Parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-006 in_valid  input  1  in_data/in_last/mode are valid this cycle.
REQ-007 in_ready  output  1  block accepts an element this cycle.
REQ-008 in_data  input  N+1  operand element.
REQ-009 in_last  input  1  final element of current frame.
REQ-010 mode  input  1  0 = max, 1 = min; sampled only on first element of a frame.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 out_value  output  N+1  winning element of the frame.
REQ-014 out_index  output  IDX_W  zero-based position of winning element.
REQ-015 out_count  output  IDX_W  number of elements in frame, saturating.
REQ-016 out_ovf  output  1  frame exceeded 2^IDX_W-1 elements.

Function
REQ-017 Element accepted only on in_valid && in_ready; result consumed only on out_valid && out_ready.
REQ-018 FSM states IDLE, ACCUM, HOLD; in_ready = 1 in IDLE and ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-019 IDLE, accept: best <= in_data, idx <= 0, pos <= 1, mode latched, ovf <= 0; next = HOLD if in_last, else ACCUM.
REQ-020 ACCUM, accept: best/idx replaced by in_data/pos only if strictly greater (max) or strictly less (min) per latched mode and SIGNED; ties keep earlier element.
REQ-021 ACCUM, accept: pos increments; at all-ones pos holds and ovf sets sticky; an element winning while pos saturated records idx = all-ones.
REQ-022 ACCUM, accept with in_last: next = HOLD; out_count = number of accepted elements (saturated).
REQ-023 Latency: out_valid asserts on the cycle after the in_last handshake; single-element frame gives idx 0, count 1.
REQ-024 HOLD: outputs stable until out_ready; on out_ready next = IDLE; one-cycle bubble between frames.
REQ-025 mode changes mid-frame have no effect on the frame in progress.
REQ-026 in_valid low in ACCUM holds all state indefinitely.
REQ-027 out_value, out_index, out_count, out_ovf are registered, no combinational path from inputs.

Reset
REQ-028 rst_n low asynchronously forces state IDLE, out_valid 0, out_value 0, out_index 0, out_count 0, out_ovf 0, latched mode 0.
REQ-029 Reset mid-frame or in HOLD discards the partial frame/result; first element after deassertion starts a new frame.

Structure
REQ-030 Shared package gcd_pkg holds FSM state enum (IDLE, ACCUM, HOLD) and mode constants MODE_MAX = 0, MODE_MIN = 1.
REQ-031 One sub-module, better_cmp: combinational compare of candidate vs best given mode and SIGNED, outputs strict-better flag.

Verification
REQ-032 N=4, SIGNED=0, mode 0, frame 3,17,9,17(last) -> out_value 17, out_index 1, out_count 4, out_ovf 0.
REQ-033 N=4, SIGNED=1, mode 1, frame 5,-3,0,-16(last) -> out_value -16 (5'b10000), out_index 3, out_count 4.
REQ-034 Single element 7 with in_last, out_ready held low 5 cycles -> out_valid 1 for 5 cycles, in_ready 0, value 7 index 0 count 1 stable; released on out_ready.
REQ-035 IDX_W=2, mode 0, frame 1,2,3,4,9(last) -> out_count 3, out_ovf 1, out_value 9, out_index 3.
REQ-036 rst_n pulsed low after 2 elements of a frame -> outputs zero immediately; next frame 6(last) -> value 6, index 0, count 1.
REQ-037 Mode flipped 0->1 after first element, in_valid gaps inserted -> result still max of frame with correct index.
